// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the multi-cycle RV32I core. Owns the PC and the instruction
//   register, runs a req/ack handshake with instruction memory and holds
//   instr_code stable for the control FSM. Misaligned PCs, bus errors and
//   memory timeouts are reported through a sticky fetch fault.
//
// Ports
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous reset, active-low
//   fetch_en     in   1   start a fetch at the current PC
//   pc_we        in   1   load pc_next into PC at the next edge
//   pc_next      in   32  next PC from the datapath
//   imem_req     out  1   instruction read request (registered)
//   imem_addr    out  32  read address, held while imem_req=1
//   imem_ack     in   1   memory returned data this cycle
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   imem_err     in   1   bus error, qualified by imem_ack
//   pc           out  32  current PC
//   instr_code   out  32  instruction register contents
//   fetch_busy   out  1   fetch in progress (any state except IDLE)
//   fetch_done   out  1   one-cycle pulse: IR updated (valid or fault)
//   fetch_fault  out  1   sticky fault flag
//   fault_cause  out  2   00 none, 01 misaligned, 10 bus error, 11 timeout
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 15,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   input  logic        pc_we,
   input  logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic [31:0] pc,
   output logic [31:0] instr_code,
   output logic        fetch_busy,
   output logic        fetch_done,
   output logic        fetch_fault,
   output logic [1:0]  fault_cause
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_BUS_ERR  = 2'b10,
      CAUSE_TIMEOUT  = 2'b11
   } cause_t;

   // Last wait cycle before a timeout fires; count starts at 0 on entry to REQ.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   cause_t      cause_q, cause_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  cnt_q, cnt_d;

   // NOTE: every variable gets a hold value before the case statement so no
   // path through the block leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      pc_d    = pc_we ? pc_next : pc_q;
      ir_d    = ir_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (fetch_en) begin
               if (pc_q[1:0] != 2'b00) begin
                  // Misaligned: no request, fault straight to DONE.
                  state_d = DONE;
                  ir_d    = NOP_INSTR;
                  cause_d = CAUSE_MISALIGN;
               end else begin
                  // Latch the old PC even if pc_we loads a new one this edge.
                  state_d = REQ;
                  addr_d  = pc_q;
                  cause_d = CAUSE_NONE;
                  cnt_d   = 8'd0;
               end
            end
         end
         REQ: begin
            if (imem_ack) begin
               state_d = DONE;
               if (imem_err) begin
                  ir_d    = NOP_INSTR;
                  cause_d = CAUSE_BUS_ERR;
               end else begin
                  ir_d    = imem_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               ir_d    = NOP_INSTR;
               cause_d = CAUSE_TIMEOUT;
            end else if (cnt_q != 8'hFF) begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cause_q <= CAUSE_NONE;
         pc_q    <= RESET_PC;
         ir_q    <= NOP_INSTR;
         addr_q  <= 32'h0000_0000;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   // All outputs decode registered state only, so imem_req has no
   // combinational path from any input and drops the instant reset asserts.
   assign imem_req    = (state_q == REQ);
   assign imem_addr   = addr_q;
   assign pc          = pc_q;
   assign instr_code  = ir_q;
   assign fetch_busy  = (state_q != IDLE);
   assign fetch_done  = (state_q == DONE);
   assign fault_cause = cause_q;
   assign fetch_fault = (cause_q != CAUSE_NONE);

endmodule
